// File: rtl/simulation_run_control_if.sv
// Run-control bundle between the bench sequencer and the harness/DUT side.
interface simulation_run_control_if #(
    parameter int unsigned CYCLE_WIDTH = 32
);
    logic                   finish_request;
    logic                   dut_reset;
    logic                   run;
    logic [CYCLE_WIDTH-1:0] cycle;
    logic                   done;
    logic                   timeout;

    // Harness side: raises finish, observes run status.
    modport master (
        output finish_request,
        input  dut_reset,
        input  run,
        input  cycle,
        input  done,
        input  timeout
    );

    // Sequencer side: samples finish, drives run status.
    modport slave (
        input  finish_request,
        output dut_reset,
        output run,
        output cycle,
        output done,
        output timeout
    );
endinterface

// File: rtl/simulation_run_control.sv
// Simulation run sequencer: holds DUT in reset, opens a run window, counts
// run cycles, ends on finish request or timeout, drains, then flags done.
module simulation_run_control #(
    parameter int unsigned CYCLE_WIDTH    = 32,
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned DRAIN_CYCLES   = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    simulation_run_control_if.slave   bus
);

    // A zero-length reset hold still needs one edge to leave HOLD.
    localparam int unsigned RC_EFF  = (RESET_CYCLES == 0) ? 1 : RESET_CYCLES;
    localparam int unsigned HOLD_W  = (RC_EFF > 1) ? $clog2(RC_EFF) : 1;
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(RC_EFF - 1);
    localparam logic [DRAIN_W-1:0]     DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CYCLE_WIDTH-1:0] TO_LAST    = CYCLE_WIDTH'(TIMEOUT_CYCLES - 1);

    // Timeout only fires when its last cycle is representable in the counter.
    localparam bit TO_FITS = (CYCLE_WIDTH >= 32) ||
                             (64'(TIMEOUT_CYCLES) <= (64'd1 << CYCLE_WIDTH));
    localparam bit TO_EN   = (TIMEOUT_CYCLES != 0) && TO_FITS;

    if ((TIMEOUT_CYCLES != 0) && !TO_FITS) begin : g_timeout_warn
        $warning("simulation_run_control: TIMEOUT_CYCLES exceeds counter range; timeout disabled");
    end

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [DRAIN_W-1:0]     r_drain_cnt;
    logic                   r_dut_reset;
    logic                   r_run;
    logic [CYCLE_WIDTH-1:0] r_cycle;
    logic                   r_done;
    logic                   r_timeout;

    logic w_finish;
    logic w_timeout_hit;

    // X/Z on the request line never counts as a finish.
    assign w_finish      = (bus.finish_request === 1'b1);
    assign w_timeout_hit = TO_EN && (r_cycle == TO_LAST);

    // Sequencer state machine with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_drain_cnt <= '0;
            r_dut_reset <= 1'b1;
            r_run       <= 1'b0;
            r_cycle     <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_dut_reset <= 1'b1;
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_hold_cnt  <= '0;
                        r_state     <= S_RUN;
                        r_dut_reset <= 1'b0;
                        r_run       <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_finish || w_timeout_hit) begin
                        r_run       <= 1'b0;
                        r_timeout   <= !w_finish;
                        r_drain_cnt <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (r_cycle != '1) begin
                        r_cycle <= r_cycle + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_DONE;
                end
            endcase
        end
    end

    assign bus.dut_reset = r_dut_reset;
    assign bus.run       = r_run;
    assign bus.cycle     = r_cycle;
    assign bus.done      = r_done;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_simulation_run_control.sv
// Directed bench for simulation_run_control: default build plus a narrow
// build with zero reset/timeout/drain settings.
module tb_simulation_run_control;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    int checks = 0;
    int errors = 0;

    simulation_run_control_if #(.CYCLE_WIDTH(32)) bus_a ();
    simulation_run_control_if #(.CYCLE_WIDTH(4))  bus_b ();

    simulation_run_control #(
        .CYCLE_WIDTH(32), .RESET_CYCLES(4), .TIMEOUT_CYCLES(1000), .DRAIN_CYCLES(8)
    ) u_dut_a (
        .clock (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    simulation_run_control #(
        .CYCLE_WIDTH(4), .RESET_CYCLES(0), .TIMEOUT_CYCLES(0), .DRAIN_CYCLES(0)
    ) u_dut_b (
        .clock (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until run rises on DUT A; returns edges taken (bounded).
    task automatic wait_run_a(output int n);
        n = 0;
        while (bus_a.run !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_dut_reset"}, 64'(bus_a.dut_reset), 64'd1);
        chk({tag, "_run"},       64'(bus_a.run),       64'd0);
        chk({tag, "_cycle"},     64'(bus_a.cycle),     64'd0);
        chk({tag, "_done"},      64'(bus_a.done),      64'd0);
        chk({tag, "_timeout"},   64'(bus_a.timeout),   64'd0);
    endtask

    task automatic chk_run_start_a(input string tag, input int n);
        chk({tag, "_hold_edges"}, 64'(n),               64'd4);
        chk({tag, "_dut_reset"},  64'(bus_a.dut_reset), 64'd0);
        chk({tag, "_cycle"},      64'(bus_a.cycle),     64'd0);
    endtask

    initial begin
        int n;
        bus_a.finish_request = 1'b0;
        bus_b.finish_request = 1'b0;

        // 1: reset for 3 edges, then release and measure hold length
        ticks(3);
        chk_reset_a("s1_rst");
        rst_a = 1'b0;
        ticks(3);
        chk("s1_hold_still_reset", 64'(bus_a.dut_reset), 64'd1);
        chk("s1_hold_no_run",      64'(bus_a.run),       64'd0);
        n = 3;
        while (bus_a.run !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk_run_start_a("s1", n);

        // 2: finish pulse at cycle 20
        ticks(20);
        chk("s2_cycle20", 64'(bus_a.cycle), 64'd20);
        bus_a.finish_request = 1'b1;
        tick();
        bus_a.finish_request = 1'b0;
        chk("s2_run_low",   64'(bus_a.run),     64'd0);
        chk("s2_cycle_frz", 64'(bus_a.cycle),   64'd20);
        chk("s2_timeout",   64'(bus_a.timeout), 64'd0);
        ticks(7);
        chk("s2_done_early", 64'(bus_a.done), 64'd0);
        tick();
        chk("s2_done", 64'(bus_a.done), 64'd1);
        bus_a.finish_request = 1'b1;
        ticks(5);
        bus_a.finish_request = 1'b0;
        chk("s2_done_sticky", 64'(bus_a.done),      64'd1);
        chk("s2_cycle_hold",  64'(bus_a.cycle),     64'd20);
        chk("s2_run_hold",    64'(bus_a.run),       64'd0);
        chk("s2_dutrst_hold", 64'(bus_a.dut_reset), 64'd0);
        chk("s2_to_hold",     64'(bus_a.timeout),   64'd0);

        // 5a: reset from DONE replays the startup
        rst_a = 1'b1;
        tick();
        chk_reset_a("s5a_rst");
        rst_a = 1'b0;
        wait_run_a(n);
        chk_run_start_a("s5a", n);

        // 3: timeout at cycle 999
        ticks(999);
        chk("s3_cycle999", 64'(bus_a.cycle),   64'd999);
        chk("s3_run_hi",   64'(bus_a.run),     64'd1);
        tick();
        chk("s3_run_low",  64'(bus_a.run),     64'd0);
        chk("s3_timeout",  64'(bus_a.timeout), 64'd1);
        chk("s3_cycle_frz",64'(bus_a.cycle),   64'd999);
        ticks(7);
        chk("s3_done_early", 64'(bus_a.done), 64'd0);
        tick();
        chk("s3_done",     64'(bus_a.done),    64'd1);
        chk("s3_to_sticky",64'(bus_a.timeout), 64'd1);

        // 5b: reset three edges into DRAIN
        rst_a = 1'b1;
        tick();
        chk_reset_a("s5b_pre");
        rst_a = 1'b0;
        wait_run_a(n);
        chk_run_start_a("s5b", n);
        ticks(5);
        bus_a.finish_request = 1'b1;
        tick();
        bus_a.finish_request = 1'b0;
        chk("s5b_cycle5", 64'(bus_a.cycle), 64'd5);
        ticks(3);
        chk("s5b_in_drain", 64'(bus_a.done), 64'd0);
        rst_a = 1'b1;
        bus_a.finish_request = 1'b1;
        tick();
        chk_reset_a("s5b_rst");

        // 4: finish held high through HOLD is ignored
        rst_a = 1'b0;
        wait_run_a(n);
        bus_a.finish_request = 1'b0;
        chk_run_start_a("s4_hold", n);
        tick();
        chk("s4_cycle1", 64'(bus_a.cycle), 64'd1);
        // X on finish is not a request
        bus_a.finish_request = 1'bx;
        tick();
        bus_a.finish_request = 1'b0;
        chk("s4_x_run",   64'(bus_a.run),   64'd1);
        chk("s4_x_cycle", 64'(bus_a.cycle), 64'd2);
        ticks(997);
        chk("s4_cycle999", 64'(bus_a.cycle), 64'd999);
        bus_a.finish_request = 1'b1;
        tick();
        bus_a.finish_request = 1'b0;
        chk("s4_run_low",   64'(bus_a.run),     64'd0);
        chk("s4_timeout",   64'(bus_a.timeout), 64'd0);
        chk("s4_cycle_frz", 64'(bus_a.cycle),   64'd999);
        ticks(7);
        chk("s4_done_early", 64'(bus_a.done), 64'd0);
        tick();
        chk("s4_done",     64'(bus_a.done),    64'd1);
        chk("s4_to_final", 64'(bus_a.timeout), 64'd0);

        // 6: narrow build, zero reset/timeout/drain
        chk("s6_rst_dutrst", 64'(bus_b.dut_reset), 64'd1);
        chk("s6_rst_run",    64'(bus_b.run),       64'd0);
        chk("s6_rst_done",   64'(bus_b.done),      64'd0);
        rst_b = 1'b0;
        tick();
        chk("s6_run_hi",  64'(bus_b.run),       64'd1);
        chk("s6_dutrst",  64'(bus_b.dut_reset), 64'd0);
        chk("s6_cycle0",  64'(bus_b.cycle),     64'd0);
        ticks(14);
        chk("s6_cycle14", 64'(bus_b.cycle), 64'd14);
        ticks(6);
        chk("s6_sat",     64'(bus_b.cycle),   64'd15);
        chk("s6_no_to",   64'(bus_b.timeout), 64'd0);
        chk("s6_run_on",  64'(bus_b.run),     64'd1);
        bus_b.finish_request = 1'b1;
        tick();
        bus_b.finish_request = 1'b0;
        chk("s6_run_low",  64'(bus_b.run),     64'd0);
        chk("s6_done",     64'(bus_b.done),    64'd1);
        chk("s6_cycle15",  64'(bus_b.cycle),   64'd15);
        chk("s6_timeout",  64'(bus_b.timeout), 64'd0);
        ticks(3);
        chk("s6_done_sticky", 64'(bus_b.done), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simulation_run_control.md
Name: simulation_run_control

Overview:
Bench-side sequencer clocked by the simulation clock generator's output. It drives the design-under-test reset, gates the run window, and counts elapsed run cycles. It ends the run either on a DUT finish request or on a cycle-count timeout, then allows a drain interval before flagging done. Sits between the simulation clock generator and the DUT/test harness in every simulation top level.

Parameters:
CYCLE_WIDTH, 32, width of the elapsed-cycle counter
RESET_CYCLES, 4, cycles dut_reset stays high after reset releases; 0 is clamped to 1
TIMEOUT_CYCLES, 1000, run cycles before forced end; 0 disables the timeout
DRAIN_CYCLES, 8, cycles between end-of-run and done; 0 means done on the next edge

Ports:
clock  input  1  simulation clock; all logic on posedge
reset  input  1  bench master reset; synchronous, active-high
finish_request  input  1  DUT/test end request; sampled only in RUN
dut_reset  output  1  reset to the DUT; registered
run  output  1  high while in RUN
cycle  output  CYCLE_WIDTH  elapsed RUN cycles
done  output  1  run complete; sticky until reset
timeout  output  1  run ended by timeout; sticky until reset

Behaviour:
- One clock; reset is synchronous and active-high (clock, reset).
- All outputs are registered. Reset values: dut_reset=1, run=0, cycle=0, done=0, timeout=0, state=HOLD, hold/drain counters=0.
- States: HOLD, RUN, DRAIN, DONE.
- HOLD:
  - dut_reset=1.
  - Each posedge with reset low increments the hold count.
  - On the edge where the count reaches max(RESET_CYCLES,1), go to RUN. On that same edge: dut_reset<=0, run<=1, cycle stays 0.
- RUN:
  - Each posedge, cycle<=cycle+1, saturating at all-ones (no wrap).
  - If finish_request===1'b1: go to DRAIN, run<=0, cycle not incremented (frozen), timeout stays 0.
  - Else if TIMEOUT_CYCLES!=0 and cycle==TIMEOUT_CYCLES-1: go to DRAIN, run<=0, timeout<=1, cycle frozen.
  - Finish takes priority over timeout on the same edge.
  - X/Z on finish_request is not a request; a simulation warning may be issued.
- DRAIN:
  - cycle frozen; dut_reset=0; run=0.
  - Drain count increments each edge. When it reaches DRAIN_CYCLES, go to DONE with done<=1.
  - DRAIN_CYCLES=0: DRAIN is bypassed; done rises on the same edge the run ends.
- DONE: terminal. All outputs hold until reset.
- finish_request is ignored in HOLD, DRAIN and DONE.
- Reset asserted in any state: on the next posedge, all outputs and state return to reset values, including clearing done/timeout. Reset overrides any simultaneous finish_request or timeout.
- Clock initially X: no state change until the first valid posedge. Outputs are X until the first edge sampling reset=1; the bench must assert reset at time 0.
- The counter compare is done at CYCLE_WIDTH width. If TIMEOUT_CYCLES exceeds 2^CYCLE_WIDTH, the timeout never fires; an elaboration-time warning is required.

Test Plan:
1. reset=1 for 3 edges, then 0, defaults → dut_reset high for exactly 4 posedges after release; run rises and dut_reset falls on the same edge; cycle=0 at that edge.
2. finish_request pulsed for one cycle while cycle==20 → next edge run=0, cycle holds 20, timeout=0; done=1 exactly 8 edges later; all outputs stable thereafter.
3. finish_request held 0 → at the edge with cycle==999, run=0 and timeout=1, cycle frozen at 999; done=1 8 edges later.
4. finish_request=1 on the edge where cycle==999 → timeout=0, DRAIN entered, done after 8 edges. Then: finish_request=X in RUN → ignored, run stays 1. finish_request=1 during HOLD → ignored, HOLD duration unchanged.
5. reset asserted in DRAIN (3 drain edges in) and separately in DONE → next edge: dut_reset=1, run=0, cycle=0, done=0, timeout=0; full sequence replays identically to scenario 1.
6. CYCLE_WIDTH=4, TIMEOUT_CYCLES=0, RESET_CYCLES=0, DRAIN_CYCLES=0:
   - dut_reset high 1 edge after release.
   - cycle saturates and holds 15, never wraps.
   - finish_request=1 → done=1 on the same edge run falls.
